// File: rtl/jk_to_sr_ff_bank.sv
// Bank of SR flip-flops built on a JK core per bit, with a configurable
// S=R=1 policy, sticky per-bit illegal flags and a saturating event counter.
module jk_to_sr_ff_bank #(
    parameter int WIDTH        = 4,
    parameter int CNT_W        = 4,
    parameter int ILLEGAL_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] illegal,
    output logic             illegal_now,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Sum is wide enough to hold a full counter plus a full popcount, so it never wraps.
    localparam int SUM_W = CNT_W + $clog2(WIDTH + 1);

    // JK inputs used when S=R=1: hold (0,0), set (1,0), reset (0,1), toggle (1,1).
    localparam logic ILL_J = (ILLEGAL_MODE == 1) || (ILLEGAL_MODE == 3);
    localparam logic ILL_K = (ILLEGAL_MODE == 2) || (ILLEGAL_MODE == 3);

    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] ill_vec;
    logic [SUM_W-1:0] pop;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_next;

    // SR-to-JK mapping, JK next state, and saturating illegal-event count.
    always_comb begin
        ill_vec = s & r & {WIDTH{en}};
        j       = (s & ~r) | (s & r & {WIDTH{ILL_J}});
        k       = (r & ~s) | (s & r & {WIDTH{ILL_K}});
        q_next  = (j & ~q) | (~k & q);

        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + SUM_W'(ill_vec[i]);
        end
        base = err_clr ? '0 : SUM_W'(illegal_cnt);
        sum  = base + pop;
        cnt_next = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // State registers; err_clr acts even while en=0 because ill_vec is then zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            q           <= '0;
            qb          <= '1;
            illegal     <= '0;
            illegal_now <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            illegal_now <= |ill_vec;
            illegal     <= (err_clr ? '0 : illegal) | ill_vec;
            illegal_cnt <= cnt_next;
            if (en) begin
                q  <= q_next;
                qb <= ~q_next;
            end
        end
    end

endmodule

// File: tb/tb_jk_to_sr_ff_bank.sv
// Scoreboard bench: directed vectors push hand-computed expectations, a
// monitor pops one entry per clock edge and compares both DUT instances
// (hold policy and toggle policy) driven by the same stimulus.
module tb_jk_to_sr_ff_bank;

    typedef struct {
        string      name;
        logic [3:0] q;
        logic [3:0] q3;
        logic [3:0] ill;
        logic       now;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [3:0] s = 4'hF;
    logic [3:0] r = 4'hF;
    logic       err_clr = 1'b0;

    logic [3:0] q0, qb0, ill0, cnt0;
    logic       now0;
    logic [3:0] q3, qb3, ill3, cnt3;
    logic       now3;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    jk_to_sr_ff_bank #(.WIDTH(4), .CNT_W(4), .ILLEGAL_MODE(0)) dut_hold (
        .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .err_clr(err_clr),
        .q(q0), .qb(qb0), .illegal(ill0), .illegal_now(now0), .illegal_cnt(cnt0)
    );

    jk_to_sr_ff_bank #(.WIDTH(4), .CNT_W(4), .ILLEGAL_MODE(3)) dut_tog (
        .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .err_clr(err_clr),
        .q(q3), .qb(qb3), .illegal(ill3), .illegal_now(now3), .illegal_cnt(cnt3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", name, fld, act, exp);
        end
    endtask

    task automatic vec(input string name, input logic rs, input logic e, input logic [3:0] sv,
                       input logic [3:0] rv, input logic clr, input logic [3:0] eq,
                       input logic [3:0] eq3, input logic [3:0] eill, input logic enow,
                       input logic [3:0] ecnt);
        exp_t x;
        @(negedge clk);
        reset   = rs;
        en      = e;
        s       = sv;
        r       = rv;
        err_clr = clr;
        x.name = name; x.q = eq; x.q3 = eq3; x.ill = eill; x.now = enow; x.cnt = ecnt;
        sb.push_back(x);
    endtask

    // Monitor: every edge presents a registered result; compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "q", q0, e.q);
            chk(e.name, "qb", qb0, ~e.q);
            chk(e.name, "illegal", ill0, e.ill);
            chk(e.name, "illegal_now", {3'b0, now0}, {3'b0, e.now});
            chk(e.name, "cnt", cnt0, e.cnt);
            chk(e.name, "q_tog", q3, e.q3);
            chk(e.name, "qb_tog", qb3, ~e.q3);
            chk(e.name, "illegal_tog", ill3, e.ill);
            chk(e.name, "cnt_tog", cnt3, e.cnt);
        end
    end

    initial begin
        //   name            rst en  s     r     clr  q     q3    ill   now   cnt
        vec("reset_a",       1, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        vec("reset_b",       1, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        vec("set5",          0, 1, 4'h5, 4'h0, 0, 4'h5, 4'h5, 4'h0, 1'b0, 4'h0);
        vec("reset_bit0",    0, 1, 4'h0, 4'h1, 0, 4'h4, 4'h4, 4'h0, 1'b0, 4'h0);
        vec("hold4",         0, 1, 4'h0, 4'h0, 0, 4'h4, 4'h4, 4'h0, 1'b0, 4'h0);
        vec("set_bit0",      0, 1, 4'h1, 4'h0, 0, 4'h5, 4'h5, 4'h0, 1'b0, 4'h0);
        vec("illegal3",      0, 1, 4'h3, 4'h3, 0, 4'h5, 4'h6, 4'h3, 1'b1, 4'h2);
        vec("after_ill",     0, 1, 4'h0, 4'h0, 0, 4'h5, 4'h6, 4'h3, 1'b0, 4'h2);
        vec("clr_with_new",  0, 1, 4'h8, 4'h8, 1, 4'h5, 4'hE, 4'h8, 1'b1, 4'h1);
        vec("clr_en0",       0, 0, 4'h0, 4'h0, 1, 4'h5, 4'hE, 4'h0, 1'b0, 4'h0);
        vec("ill_F_1",       0, 1, 4'hF, 4'hF, 0, 4'h5, 4'h1, 4'hF, 1'b1, 4'h4);
        vec("ill_F_2",       0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hE, 4'hF, 1'b1, 4'h8);
        vec("ill_F_3",       0, 1, 4'hF, 4'hF, 0, 4'h5, 4'h1, 4'hF, 1'b1, 4'hC);
        vec("ill_3_to14",    0, 1, 4'h3, 4'h3, 0, 4'h5, 4'h2, 4'hF, 1'b1, 4'hE);
        vec("sat_15",        0, 1, 4'hF, 4'hF, 0, 4'h5, 4'hD, 4'hF, 1'b1, 4'hF);
        vec("sat_stay",      0, 1, 4'hF, 4'hF, 0, 4'h5, 4'h2, 4'hF, 1'b1, 4'hF);
        vec("quiet",         0, 1, 4'h0, 4'h0, 0, 4'h5, 4'h2, 4'hF, 1'b0, 4'hF);
        vec("en0_frozen",    0, 0, 4'hF, 4'h0, 0, 4'h5, 4'h2, 4'hF, 1'b0, 4'hF);
        vec("en0_ill_ign",   0, 0, 4'hF, 4'hF, 0, 4'h5, 4'h2, 4'hF, 1'b0, 4'hF);
        vec("setF",          0, 1, 4'hF, 4'h0, 0, 4'hF, 4'hF, 4'hF, 1'b0, 4'hF);
        vec("mid_reset",     1, 1, 4'hF, 4'hF, 0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        vec("post_hold",     0, 1, 4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
        vec("post_setA",     0, 1, 4'hA, 4'h0, 0, 4'hA, 4'hA, 4'h0, 1'b0, 4'h0);
        vec("post_ill",      0, 1, 4'h2, 4'h2, 0, 4'hA, 4'h8, 4'h2, 1'b1, 4'h1);

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
